uart_tx_buf: RTL and testbench

UART_TX_BUF -- requirements
Module: uart_tx_buf

---
 rtl/uart_pkg.sv | 35 +++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/uart_tx_buf.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx_buf.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter.
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit).
package uart_pkg;

    localparam int unsigned DATA_BITS        = 8;
    localparam int unsigned FRAME_BITS_NOPAR = 10;
    localparam int unsigned FRAME_BITS_PAR   = 11;

`ifdef UART_TX_PARITY_EN
    localparam int unsigned FRAME_BITS = FRAME_BITS_PAR;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Even parity: XOR of all data bits.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
        return ^b;
    endfunction
`else
    localparam int unsigned FRAME_BITS = FRAME_BITS_NOPAR;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd4
    } state_t;
`endif

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic             wr_ok, rd_ok;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    // Next pointer and occupancy; push+pop together leaves the count alone.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage array; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= din;
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: bytes are queued in sync_fifo and sent
// LSB first as START / 8 DATA / [PARITY] / STOP, each CLKS_PER_BIT cycles.
// Optional feature macro: UART_TX_PARITY_EN (even parity bit before STOP).
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       full,
    output logic       overflow,
    output logic       q,
    output logic       active,
    output logic       done
);

    localparam logic [7:0] CNT_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

    logic       fifo_full, fifo_empty, wr_en, rd_en;
    logic [7:0] fifo_dout;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic       q_q, q_d;
    logic       active_q, active_d;
    logic       done_q, done_d;
    logic       overflow_q;
    logic       bit_end;
`ifdef UART_TX_PARITY_EN
    logic       par_q, par_d;
`endif

    assign wr_en    = data_valid && !fifo_full;
    assign full     = fifo_full;
    assign overflow = overflow_q;
    assign q        = q_q;
    assign active   = active_q;
    assign done     = done_q;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_en),
        .din   (data_in),
        .rd_en (rd_en),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Frame sequencing; outputs are derived from the next state so that
    // the registered line changes on the same edge as the state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        rd_en   = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        bit_end = (cnt_q == CNT_LAST);

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    rd_en   = 1'b1;
                    shift_d = fifo_dout;
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = ST_START;
`ifdef UART_TX_PARITY_EN
                    par_d   = even_parity(fifo_dout);
`endif
                end
            end
            ST_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        q_d = 1'b1;
        case (state_d)
            ST_START:  q_d = 1'b0;
            ST_DATA:   q_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: q_d = par_d;
`endif
            default:   q_d = 1'b1;
        endcase
        active_d = (state_d != ST_IDLE);
        done_d   = (state_d == ST_STOP) && (cnt_d == CNT_LAST);
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            q_q        <= 1'b1;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            q_q        <= q_d;
            active_q   <= active_d;
            done_q     <= done_d;
            overflow_q <= data_valid && fifo_full;
`ifdef UART_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Self-checking bench for uart_tx_buf (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Honours UART_TX_PARITY_EN when the build defines it.
module tb_uart_tx_buf;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FL  = 11;
    localparam bit PAR = 1'b1;
`else
    localparam int FL  = 10;
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       data_valid;
    logic       full, overflow, q, active, done;

    int checks = 0;
    int errors = 0;

    uart_tx_buf #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .full       (full),
        .overflow   (overflow),
        .q          (q),
        .active     (active),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Line monitor: decodes frames from q by mid-bit sampling.
    logic [7:0]  rx_data[$];
    logic        rx_par[$];
    logic        rx_stop[$];
    int          rx_gap[$];
    int          mon_pos  = -1;
    int          idle_run = 0;
    int          mon_gap  = 0;
    logic [10:0] fbits    = '0;
    int          ovf_cnt  = 0;
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (overflow === 1'b1) ovf_cnt++;
        if (done === 1'b1) done_cnt++;
        if (rst === 1'b1) begin
            mon_pos  = -1;
            idle_run = 0;
        end else begin
            if (mon_pos < 0) begin
                if (q === 1'b0) begin
                    mon_pos = 0;
                    mon_gap = idle_run;
                    fbits   = '0;
                end else begin
                    idle_run++;
                end
            end
            if (mon_pos >= 0) begin
                if (mon_pos % CPB == CPB / 2) fbits[mon_pos / CPB] = q;
                mon_pos++;
                if (mon_pos == FL * CPB) begin
                    rx_data.push_back(fbits[8:1]);
                    rx_par.push_back(fbits[9]);
                    rx_stop.push_back(fbits[FL-1]);
                    rx_gap.push_back(mon_gap);
                    mon_pos  = -1;
                    idle_run = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rx();
        rx_data.delete();
        rx_par.delete();
        rx_stop.delete();
        rx_gap.delete();
    endtask

    task automatic wait_rx(input int n, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (rx_data.size() >= n) begin
                timed_out = 1'b0;
                break;
            end
            tick();
        end
    endtask

    // Expected line level of bit k of a frame carrying byte b.
    function automatic logic exp_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (PAR && k == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic test_reset();
        rst        = 1'b1;
        data_valid = 1'b0;
        data_in    = '0;
        repeat (3) tick();
        checks++; if (q !== 1'b1)        begin errors++; $display("FAIL reset_q got=%b exp=1", q); end
        checks++; if (active !== 1'b0)   begin errors++; $display("FAIL reset_active got=%b exp=0", active); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (full !== 1'b0)     begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
        rst = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_single_frame(input logic [7:0] b);
        repeat (3) tick();
        data_in    = b;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        checks++; if (q !== 1'b1) begin errors++; $display("FAIL latency_n1_q byte=%h got=%b exp=1", b, q); end
        tick();
        for (int c = 0; c < FL * CPB; c++) begin
            checks++;
            if (q !== exp_bit(b, c / CPB)) begin
                errors++;
                $display("FAIL frame_q byte=%h cycle=%0d got=%b exp=%b", b, c, q, exp_bit(b, c / CPB));
            end
            checks++;
            if (active !== 1'b1) begin errors++; $display("FAIL frame_active byte=%h cycle=%0d got=%b exp=1", b, c, active); end
            checks++;
            if (done !== (c == FL * CPB - 1)) begin
                errors++;
                $display("FAIL frame_done byte=%h cycle=%0d got=%b exp=%b", b, c, done, (c == FL * CPB - 1));
            end
            tick();
        end
        checks++; if (q !== 1'b1)      begin errors++; $display("FAIL after_frame_q got=%b exp=1", q); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL after_frame_active got=%b exp=0", active); end
        checks++; if (done !== 1'b0)   begin errors++; $display("FAIL after_frame_done got=%b exp=0", done); end
    endtask

    task automatic test_back_to_back();
        int ovf0;
        bit to;
        repeat (3) tick();
        clear_rx();
        ovf0 = ovf_cnt;
        for (int i = 0; i < 5; i++) begin
            data_in    = 8'h11 + 8'(i);
            data_valid = 1'b1;
            tick();
        end
        data_valid = 1'b0;
        wait_rx(5, to);
        checks++; if (to) begin errors++; $display("FAIL b2b_timeout got=%0d frames exp=5", rx_data.size()); end
        for (int i = 0; i < 5 && i < rx_data.size(); i++) begin
            checks++;
            if (rx_data[i] !== 8'h11 + 8'(i)) begin errors++; $display("FAIL b2b_data idx=%0d got=%h exp=%h", i, rx_data[i], 8'h11 + 8'(i)); end
            checks++;
            if (rx_stop[i] !== 1'b1) begin errors++; $display("FAIL b2b_stop idx=%0d got=%b exp=1", i, rx_stop[i]); end
            if (PAR) begin
                checks++;
                if (rx_par[i] !== ^rx_data[i]) begin errors++; $display("FAIL b2b_parity idx=%0d got=%b exp=%b", i, rx_par[i], ^rx_data[i]); end
            end
            if (i > 0) begin
                checks++;
                if (rx_gap[i] != 1) begin errors++; $display("FAIL b2b_gap idx=%0d got=%0d exp=1", i, rx_gap[i]); end
            end
        end
        checks++; if (ovf_cnt != ovf0) begin errors++; $display("FAIL b2b_overflow got=%0d pulses exp=0", ovf_cnt - ovf0); end
    endtask

    task automatic test_overflow();
        logic [7:0] b[5];
        int ovf0;
        bit to;
        for (int i = 0; i < 5; i++) begin
            b[i] = 8'($urandom_range(0, 255));
            if (b[i] == 8'hEE) b[i] = 8'h5A;
        end
        repeat (3) tick();
        clear_rx();
        ovf0 = ovf_cnt;
        data_in    = b[0];
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        tick();
        for (int i = 1; i < 5; i++) begin
            data_in    = b[i];
            data_valid = 1'b1;
            tick();
        end
        data_valid = 1'b0;
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full got=%b exp=1", full); end
        data_in    = 8'hEE;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse got=%b exp=1", overflow); end
        tick();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_pulse_end got=%b exp=0", overflow); end
        wait_rx(5, to);
        checks++; if (to) begin errors++; $display("FAIL ovf_timeout got=%0d frames exp=5", rx_data.size()); end
        repeat (FL * CPB + 4) tick();
        checks++; if (rx_data.size() != 5) begin errors++; $display("FAIL ovf_frame_count got=%0d exp=5", rx_data.size()); end
        for (int i = 0; i < 5 && i < rx_data.size(); i++) begin
            checks++;
            if (rx_data[i] !== b[i]) begin errors++; $display("FAIL ovf_data idx=%0d got=%h exp=%h", i, rx_data[i], b[i]); end
        end
        checks++; if (ovf_cnt - ovf0 != 1) begin errors++; $display("FAIL ovf_count got=%0d exp=1", ovf_cnt - ovf0); end
    endtask

    task automatic test_simul_push_pop();
        logic [7:0] b[5];
        int ovf0;
        bit to, seen;
        for (int i = 0; i < 5; i++) b[i] = 8'($urandom_range(0, 255));
        repeat (3) tick();
        clear_rx();
        ovf0 = ovf_cnt;
        for (int i = 0; i < 4; i++) begin
            data_in    = b[i];
            data_valid = 1'b1;
            tick();
        end
        data_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        checks++; if (!seen) begin errors++; $display("FAIL simul_done_timeout got=0 exp=1"); end
        tick();
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL simul_idle got=%b exp=0", active); end
        checks++; if (full !== 1'b0)   begin errors++; $display("FAIL simul_full_before got=%b exp=0", full); end
        data_in    = b[4];
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        checks++; if (full !== 1'b0)     begin errors++; $display("FAIL simul_full_after got=%b exp=0", full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL simul_overflow got=%b exp=0", overflow); end
        wait_rx(5, to);
        checks++; if (to) begin errors++; $display("FAIL simul_timeout got=%0d frames exp=5", rx_data.size()); end
        for (int i = 0; i < 5 && i < rx_data.size(); i++) begin
            checks++;
            if (rx_data[i] !== b[i]) begin errors++; $display("FAIL simul_data idx=%0d got=%h exp=%h", i, rx_data[i], b[i]); end
        end
        checks++; if (ovf_cnt != ovf0) begin errors++; $display("FAIL simul_ovf_count got=%0d exp=0", ovf_cnt - ovf0); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        int done0, bad;
        b = 8'($urandom_range(0, 255));
        repeat (3) tick();
        clear_rx();
        data_in    = b;
        data_valid = 1'b1;
        tick();
        data_in = ~b;
        tick();
        data_in = b ^ 8'h3C;
        tick();
        data_valid = 1'b0;
        // now in frame cycle 1; DATA bit 3 spans frame cycles 16..19
        repeat (16) tick();
        checks++; if (q !== b[3]) begin errors++; $display("FAIL rstmid_bit3 got=%b exp=%b", q, b[3]); end
        done0 = done_cnt;
        rst = 1'b1;
        tick();
        checks++; if (q !== 1'b1)        begin errors++; $display("FAIL rstmid_q got=%b exp=1", q); end
        checks++; if (active !== 1'b0)   begin errors++; $display("FAIL rstmid_active got=%b exp=0", active); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL rstmid_done got=%b exp=0", done); end
        checks++; if (full !== 1'b0)     begin errors++; $display("FAIL rstmid_full got=%b exp=0", full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rstmid_overflow got=%b exp=0", overflow); end
        tick();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 3 * FL * CPB; i++) begin
            tick();
            if (q !== 1'b1 || active !== 1'b0) bad++;
        end
        checks++; if (bad != 0)               begin errors++; $display("FAIL rstmid_resume got=%0d busy cycles exp=0", bad); end
        checks++; if (done_cnt != done0)      begin errors++; $display("FAIL rstmid_done_count got=%0d exp=0", done_cnt - done0); end
        checks++; if (rx_data.size() != 0)    begin errors++; $display("FAIL rstmid_frames got=%0d exp=0", rx_data.size()); end
    endtask

    initial begin
        test_reset();
        test_single_frame(8'hA5);
        test_single_frame(8'h01);
        test_single_frame(8'($urandom_range(0, 255)));
        test_back_to_back();
        test_overflow();
        test_simul_push_pop();
        test_reset_mid_frame();
        test_single_frame(8'($urandom_range(0, 255)));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
